// File: rtl/inst_encoder_loader.sv
// Packs symbolic instruction requests into 32-bit pipeline-CPU instruction words
// and streams them into instruction memory through a write/acknowledge port.
module inst_encoder_loader #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_mnem,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_sa,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  input  logic              im_ack,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_WRITE, S_FULL} state_t;

  state_t              r_state, w_nxt;
  logic                r_we, r_full, r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_count;
  logic [31:0]         r_wdata, w_enc;
  logic                w_ready, w_accept, w_illegal, w_set_we, w_done;

  // Encoder: unused fields stay zero; shifts force rs to zero and carry sa.
  always_comb begin
    w_enc = '0;
    case (req_mnem)
      4'd0:  w_enc = {6'b000000, req_rs, req_rt, req_rd, 5'd0, 6'b000001};
      4'd1:  w_enc = {6'b000001, req_rs, req_rt, req_rd, 5'd0, 6'b000001};
      4'd2:  w_enc = {6'b000001, req_rs, req_rt, req_rd, 5'd0, 6'b000010};
      4'd3:  w_enc = {6'b000001, req_rs, req_rt, req_rd, 5'd0, 6'b000100};
      4'd4:  w_enc = {6'b000010, 5'd0, req_rt, req_rd, req_sa, 6'b000010};
      4'd5:  w_enc = {6'b000010, 5'd0, req_rt, req_rd, req_sa, 6'b000011};
      4'd6:  w_enc = {6'b000101, req_rs, req_rt, req_imm};
      4'd7:  w_enc = {6'b001001, req_rs, req_rt, req_imm};
      4'd8:  w_enc = {6'b001010, req_rs, req_rt, req_imm};
      4'd9:  w_enc = {6'b001100, req_rs, req_rt, req_imm};
      4'd10: w_enc = {6'b001101, req_rs, req_rt, req_imm};
      4'd11: w_enc = {6'b001110, req_rs, req_rt, req_imm};
      4'd12: w_enc = {6'b001111, req_rs, req_rt, req_imm};
      4'd13: w_enc = {6'b010000, req_rs, req_rt, req_imm};
      4'd14: w_enc = {6'b010010, req_target};
      default: w_enc = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_ready   = 1'b0;
    w_accept  = 1'b0;
    w_illegal = 1'b0;
    w_set_we  = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = resetn & ~r_full;
        if (req_valid && w_ready) begin
          if (req_mnem == 4'd15) begin
            w_illegal = 1'b1;
          end else begin
            w_accept = 1'b1;
            w_nxt    = S_ENC;
          end
        end
      end
      S_ENC: begin
        w_set_we = 1'b1;
        w_nxt    = S_WRITE;
      end
      S_WRITE: begin
        if (im_ack) begin
          w_done = 1'b1;
          w_nxt  = (r_count == LAST) ? S_FULL : S_IDLE;
        end
      end
      default: ;
    endcase
    // clear abandons any pending write and wins over a same-cycle ack; a request
    // accepted in IDLE on the clear edge still proceeds against the rewound pointer.
    if (clear) begin
      w_nxt    = w_accept ? S_ENC : S_IDLE;
      w_set_we = 1'b0;
      w_done   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_we    <= 1'b0;
      r_addr  <= BASE;
      r_wdata <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) r_wdata <= w_enc;
      if (clear) begin
        r_we    <= 1'b0;
        r_addr  <= BASE;
        r_count <= '0;
        r_full  <= 1'b0;
        r_err   <= w_illegal;
      end else begin
        if (w_illegal) r_err <= 1'b1;
        if (w_set_we)  r_we  <= 1'b1;
        if (w_done) begin
          r_we    <= 1'b0;
          r_addr  <= r_addr + ADDR_W'(1);
          r_count <= r_count + (ADDR_W+1)'(1);
          if (r_count == LAST) r_full <= 1'b1;
        end
      end
    end
  end

  assign req_ready = w_ready;
  assign im_we     = r_we;
  assign im_addr   = r_addr;
  assign im_wdata  = r_wdata;
  assign count     = r_count;
  assign full      = r_full;
  assign err       = r_err;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: directed scenarios plus randomized requests
// checked against a table-driven encoding model and a write-address scoreboard.
module tb_inst_encoder_loader;

  logic        clock = 1'b0, resetn = 1'b1, clear = 1'b0, req_valid = 1'b0, im_ack = 1'b0;
  logic [3:0]  req_mnem = '0;
  logic [4:0]  req_rs = '0, req_rt = '0, req_rd = '0, req_sa = '0;
  logic [15:0] req_imm = '0;
  logic [25:0] req_target = '0;

  logic        req_ready, im_we, full, err;
  logic [5:0]  im_addr;
  logic [31:0] im_wdata;
  logic [6:0]  count;

  logic        rdy2, we2, full2, err2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [2:0]  count2;

  int n_tests = 0, n_fail = 0;
  int m_ptr = 0, m_cnt = 0;
  bit m_err = 0;
  bit ack_rand = 0;
  logic [37:0] wq[$];
  logic [37:0] exp_q[$];

  inst_encoder_loader #(.ADDR_W(6), .BASE_ADDR(0)) dut (
    .clock(clock), .resetn(resetn), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req_mnem(req_mnem), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_sa(req_sa),
    .req_imm(req_imm), .req_target(req_target), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .im_ack(im_ack), .count(count), .full(full), .err(err));

  inst_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clock(clock), .resetn(resetn), .clear(clear), .req_valid(req_valid), .req_ready(rdy2),
    .req_mnem(req_mnem), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_sa(req_sa),
    .req_imm(req_imm), .req_target(req_target), .im_we(we2), .im_addr(addr2),
    .im_wdata(wdata2), .im_ack(im_ack), .count(count2), .full(full2), .err(err2));

  always #5 clock = ~clock;

  // Scoreboard of completed writes as seen on the memory port.
  always @(posedge clock)
    if (resetn && im_we && im_ack && !clear) wq.push_back({im_addr, im_wdata});

  always @(negedge clock)
    if (ack_rand) im_ack = 1'($urandom_range(0, 1));

  function automatic logic [31:0] model_enc(input int m, input logic [4:0] rs, rt, rd, sa,
                                            input logic [15:0] imm, input logic [25:0] tgt);
    int op_t [15] = '{0, 1, 1, 1, 2, 2, 5, 9, 10, 12, 13, 14, 15, 16, 18};
    int fn_t [6]  = '{1, 1, 2, 4, 2, 3};
    logic [31:0] op;
    op = 32'(op_t[m]) << 26;
    if (m < 4)  return op | (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn_t[m]);
    if (m < 6)  return op | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sa) << 6) | 32'(fn_t[m]);
    if (m < 14) return op | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    return op | 32'(tgt);
  endfunction

  task automatic model_accept(input int m, input logic [4:0] rs, rt, rd, sa,
                              input logic [15:0] imm, input logic [25:0] tgt);
    if (m == 15) m_err = 1;
    else begin
      exp_q.push_back({6'(m_ptr), model_enc(m, rs, rt, rd, sa, imm, tgt)});
      m_ptr = (m_ptr + 1) % 64;
      m_cnt++;
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_err = 0;
    wq.delete(); exp_q.delete();
  endtask

  task automatic set_req(input int m, input logic [4:0] rs, rt, rd, sa,
                         input logic [15:0] imm, input logic [25:0] tgt);
    req_mnem = 4'(m); req_rs = rs; req_rt = rt; req_rd = rd; req_sa = sa;
    req_imm = imm; req_target = tgt;
  endtask

  // Presents a request and returns just after the accepting edge.
  task automatic send(input int m, input logic [4:0] rs, rt, rd, sa,
                      input logic [15:0] imm, input logic [25:0] tgt, input bit use2);
    bit ok;
    ok = 0;
    @(negedge clock);
    set_req(m, rs, rt, rd, sa, imm, tgt);
    req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (use2 ? rdy2 : req_ready) begin ok = 1; break; end
      @(negedge clock);
    end
    if (ok) begin
      @(posedge clock);
      #1;
    end else begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: req_ready stayed 0, required 1 within 200 cycles");
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!im_we && req_ready && count == 7'(m_cnt)) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: count=%0d we=%0b, required count=%0d idle", count, im_we, m_cnt);
    end
  endtask

  task automatic wait_we(input bit use2);
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (use2 ? we2 : im_we) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL we_timeout: im_we never rose, required 1 within 50 cycles");
    end
  endtask

  task automatic pulse_clear();
    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    req_valid = 1'b1;
    #20;
    n_tests++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    n_tests++;
    if ({im_we, full, err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: we/full/err got %b want 000", {im_we, full, err});
    end
    n_tests++;
    if ({im_addr, count, im_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_regs: addr=%h count=%h wdata=%h want all 0", im_addr, count, im_wdata);
    end
    req_valid = 1'b0;
    @(negedge clock); resetn = 1'b1;
    model_reset();
    @(negedge clock);
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b want 1", req_ready); end
  endtask

  task automatic test_basic();
    im_ack = 1'b1;
    send(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 0);
    model_accept(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    @(negedge clock);
    n_tests++;
    if (im_we !== 1'b0) begin n_fail++; $display("FAIL enc_cycle_we: got %b want 0", im_we); end
    @(negedge clock);
    n_tests++;
    if ({im_we, im_addr, im_wdata} !== {1'b1, 6'd0, 32'h00221801}) begin
      n_fail++; $display("FAIL add_write: we=%b addr=%h data=%h want 1/00/00221801", im_we, im_addr, im_wdata);
    end
    @(negedge clock);
    n_tests++;
    if ({im_we, count} !== {1'b0, 7'd1}) begin
      n_fail++; $display("FAIL add_done: we=%b count=%0d want 0/1", im_we, count);
    end
    pulse_clear();
    model_reset();
    n_tests++;
    if (count !== 7'd0) begin n_fail++; $display("FAIL clear_count: got %0d want 0", count); end
    send(5, 5'd9, 5'd4, 5'd5, 5'd7, 16'h0, 26'h0, 0);
    model_accept(5, 5'd9, 5'd4, 5'd5, 5'd7, 16'h0, 26'h0);
    send(14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010, 0);
    model_accept(14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010);
    drain();
    n_tests++;
    if (wq.size() !== 2) begin n_fail++; $display("FAIL basic_nwrites: got %0d want 2", wq.size()); end
    else begin
      n_tests++;
      if (wq[0] !== {6'd0, 32'h080429C3}) begin n_fail++; $display("FAIL sll_word: got %h want 00080429C3", wq[0]); end
      n_tests++;
      if (wq[1] !== {6'd1, 32'h48000010}) begin n_fail++; $display("FAIL j_word: got %h want 0148000010", wq[1]); end
    end
  endtask

  task automatic test_back_to_back();
    im_ack = 1'b1;
    @(negedge clock);
    set_req(1, 5'd3, 5'd6, 5'd9, 5'd0, 16'h0, 26'h0);
    req_valid = 1'b1;
    repeat (9) @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (3) model_accept(1, 5'd3, 5'd6, 5'd9, 5'd0, 16'h0, 26'h0);
    @(negedge clock);
    n_tests++;
    if ({im_we, count} !== {1'b0, 7'(m_cnt)}) begin
      n_fail++; $display("FAIL back_to_back: we=%b count=%0d want 0/%0d", im_we, count, m_cnt);
    end
  endtask

  task automatic test_ack_delay();
    logic [5:0]  a;
    logic [31:0] d;
    logic [4:0]  rs, rt, rd;
    bit          bad;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    bad = 0;
    im_ack = 1'b0;
    send(3, rs, rt, rd, 5'd0, 16'h0, 26'h0, 0);
    model_accept(3, rs, rt, rd, 5'd0, 16'h0, 26'h0);
    wait_we(0);
    a = im_addr; d = im_wdata;
    n_tests++;
    if ({a, d} !== exp_q[exp_q.size()-1]) begin
      n_fail++; $display("FAIL delay_word: got %h want %h", {a, d}, exp_q[exp_q.size()-1]);
    end
    for (int i = 0; i < 5; i++) begin
      if (!im_we || im_addr !== a || im_wdata !== d || req_ready !== 1'b0) bad = 1;
      if (i < 4) @(negedge clock);
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL hold_stable: outputs changed during wait, required stable"); end
    im_ack = 1'b1;
    @(negedge clock);
    n_tests++;
    if ({im_we, count} !== {1'b0, 7'(m_cnt)}) begin
      n_fail++; $display("FAIL delay_done: we=%b count=%0d want 0/%0d", im_we, count, m_cnt);
    end
    repeat (3) @(negedge clock);
    n_tests++;
    if ({count, im_addr} !== {7'(m_cnt), 6'(m_ptr)}) begin
      n_fail++; $display("FAIL idle_ack: count=%0d addr=%0d want %0d/%0d", count, im_addr, m_cnt, m_ptr);
    end
  endtask

  task automatic test_illegal();
    int c0;
    im_ack = 1'b1;
    c0 = m_cnt;
    send(15, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1234, 26'h0, 0);
    model_accept(15, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1234, 26'h0);
    n_tests++;
    if ({err, req_ready, count} !== {1'b1, 1'b1, 7'(c0)}) begin
      n_fail++; $display("FAIL illegal: err=%b ready=%b count=%0d want 1/1/%0d", err, req_ready, count, c0);
    end
    send(10, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFC, 26'h0, 0);
    model_accept(10, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFC, 26'h0);
    drain();
    n_tests++;
    if (wq.size() == 0 || wq[wq.size()-1] !== {6'(c0), 32'h3408FFFC}) begin
      n_fail++; $display("FAIL lw_after_illegal: got %h want %h", wq.size() ? wq[wq.size()-1] : 38'h0, {6'(c0), 32'h3408FFFC});
    end
  endtask

  task automatic test_random();
    int m;
    logic [4:0] rs, rt, rd, sa;
    logic [15:0] imm;
    logic [25:0] tgt;
    ack_rand = 1;
    for (int i = 0; i < 36; i++) begin
      m = int'($urandom_range(0, 15));
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sa = 5'($urandom);
      imm = 16'($urandom); tgt = 26'($urandom);
      send(m, rs, rt, rd, sa, imm, tgt, 0);
      model_accept(m, rs, rt, rd, sa, imm, tgt);
    end
    ack_rand = 0;
    im_ack = 1'b1;
    drain();
    n_tests++;
    if (wq.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL rand_nwrites: got %0d want %0d", wq.size(), exp_q.size());
    end else begin
      for (int i = 0; i < wq.size(); i++) begin
        n_tests++;
        if (wq[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand_write[%0d]: got %h want %h", i, wq[i], exp_q[i]);
        end
      end
    end
    n_tests++;
    if ({count, im_addr, err} !== {7'(m_cnt), 6'(m_ptr), m_err}) begin
      n_fail++; $display("FAIL rand_state: count=%0d addr=%0d err=%b want %0d/%0d/%b", count, im_addr, err, m_cnt, m_ptr, m_err);
    end
  endtask

  task automatic test_full();
    logic [31:0] w5;
    bit bad, ok;
    im_ack = 1'b1;
    pulse_clear();
    model_reset();
    n_tests++;
    if ({full2, count2} !== 4'b0000) begin n_fail++; $display("FAIL full_pre: full=%b count=%0d want 0/0", full2, count2); end
    for (int i = 0; i < 4; i++) send(int'($urandom_range(0, 14)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom), 1);
    ok = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clock); if (full2) begin ok = 1; break; end end
    n_tests++;
    if (!ok || count2 !== 3'd4 || rdy2 !== 1'b0) begin
      n_fail++; $display("FAIL full_set: full=%b count=%0d ready=%b want 1/4/0", full2, count2, rdy2);
    end
    set_req(8, 5'd2, 5'd3, 5'd0, 5'd0, 16'hA5A5, 26'h0);
    w5 = model_enc(8, 5'd2, 5'd3, 5'd0, 5'd0, 16'hA5A5, 26'h0);
    req_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (rdy2 !== 1'b0 || we2 !== 1'b0 || count2 !== 3'd4) bad = 1;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL full_hold: request consumed while full, required held"); end
    clear = 1'b1;
    @(negedge clock); clear = 1'b0;
    n_tests++;
    if ({full2, count2, rdy2} !== {1'b0, 3'd0, 1'b1}) begin
      n_fail++; $display("FAIL full_clear: full=%b count=%0d ready=%b want 0/0/1", full2, count2, rdy2);
    end
    @(posedge clock); #1 req_valid = 1'b0;
    wait_we(1);
    n_tests++;
    if ({addr2, wdata2} !== {2'd0, w5}) begin
      n_fail++; $display("FAIL fifth_write: addr=%0d data=%h want 0/%h", addr2, wdata2, w5);
    end
    @(negedge clock);
    n_tests++;
    if ({we2, count2, full2} !== {1'b0, 3'd1, 1'b0}) begin
      n_fail++; $display("FAIL fifth_done: we=%b count=%0d full=%b want 0/1/0", we2, count2, full2);
    end
  endtask

  task automatic test_clear_write();
    im_ack = 1'b1;
    repeat (4) @(negedge clock);
    pulse_clear();
    im_ack = 1'b0;
    send(2, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0, 0);
    wait_we(0);
    @(negedge clock);
    clear = 1'b1; im_ack = 1'b1;
    @(negedge clock);
    clear = 1'b0; im_ack = 1'b0;
    n_tests++;
    if ({im_we, count, im_addr} !== '0) begin
      n_fail++; $display("FAIL clear_in_write: we=%b count=%0d addr=%0d want 0/0/0", im_we, count, im_addr);
    end
    @(negedge clock);
    n_tests++;
    if ({req_ready, im_we, count} !== {1'b1, 1'b0, 7'd0}) begin
      n_fail++; $display("FAIL clear_idle: ready=%b we=%b count=%0d want 1/0/0", req_ready, im_we, count);
    end
  endtask

  task automatic test_reset_write();
    im_ack = 1'b1;
    send(6, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0042, 26'h0, 0);
    repeat (3) @(negedge clock);
    n_tests++;
    if (count !== 7'd1) begin n_fail++; $display("FAIL pre_abort_count: got %0d want 1", count); end
    im_ack = 1'b0;
    send(7, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0042, 26'h0, 0);
    wait_we(0);
    #2 resetn = 1'b0;
    #1;
    n_tests++;
    if ({im_we, count, req_ready} !== {1'b0, 7'd0, 1'b0}) begin
      n_fail++; $display("FAIL async_abort: we=%b count=%0d ready=%b want 0/0/0", im_we, count, req_ready);
    end
    @(negedge clock); resetn = 1'b1;
    model_reset();
    @(negedge clock);
    n_tests++;
    if ({im_we, count, im_addr, req_ready} !== {1'b0, 7'd0, 6'd0, 1'b1}) begin
      n_fail++; $display("FAIL after_abort: we=%b count=%0d addr=%0d ready=%b want 0/0/0/1", im_we, count, im_addr, req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ack_delay();
    test_illegal();
    test_random();
    test_full();
    test_clear_write();
    test_reset_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
